// File: rtl/huffman_gen.sv
// huffman_gen: counts symbols 1..NSYM over a frame of TOTAL accepted samples, then
// builds a Huffman code with one node merge per cycle. Define HUFF_RESTART_EN to re-arm counting after each frame.
module huffman_gen #(
    parameter int NSYM   = 6,
    parameter int CNT_W  = 8,
    parameter int TOTAL  = 100,
    parameter int CODE_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gray_valid,
    input  logic [7:0]             gray_data,
    output logic                   CNT_valid,
    output logic [NSYM*CNT_W-1:0]  CNT,
    output logic                   code_valid,
    output logic [NSYM*CODE_W-1:0] HC,
    output logic [NSYM*CODE_W-1:0] M,
    output logic                   busy
);
    localparam int LEN_W  = $clog2(CODE_W + 1);
    localparam int IDX_W  = $clog2(NSYM);
    localparam int NACT_W = $clog2(NSYM + 1);

    typedef enum logic [2:0] {COUNT, REPORT, MERGE, OUT, DONE} state_t;
    state_t state;

    logic [CNT_W-1:0]  sum;
    logic [CNT_W-1:0]  weight [NSYM];
    logic [NSYM-1:0]   member [NSYM];
    logic [NSYM-1:0]   active;
    logic [CODE_W-1:0] code [NSYM];
    logic [LEN_W-1:0]  len [NSYM];
    logic [NACT_W-1:0] nact;

    logic [NSYM-1:0]   hit;
    logic [NACT_W-1:0] nz_cnt;
    logic              a_fnd, b_fnd;
    logic [IDX_W-1:0]  a_idx, b_idx, lo_idx, hi_idx;
    logic [CNT_W-1:0]  a_w, b_w;
    logic [NSYM-1:0]   a_mem, b_mem;
    logic [CODE_W-1:0] code_nxt [NSYM];
    logic [LEN_W-1:0]  len_nxt [NSYM];

    function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [CODE_W:0] t;
        t = {{CODE_W{1'b0}}, 1'b1} << l;
        t = t - {{CODE_W{1'b0}}, 1'b1};
        return t[CODE_W-1:0];
    endfunction

    always_comb begin
        hit    = '0;
        nz_cnt = '0;
        for (int s = 0; s < NSYM; s++) begin
            hit[s] = gray_valid && (gray_data == 8'(s + 1));
            nz_cnt = nz_cnt + NACT_W'(|CNT[s*CNT_W +: CNT_W]);
        end
    end

    // Ascending scan with strict '<' makes the lower slot win on equal weights.
    always_comb begin
        a_fnd = 1'b0;
        b_fnd = 1'b0;
        a_idx = '0;
        b_idx = '0;
        a_w   = '0;
        b_w   = '0;
        a_mem = '0;
        b_mem = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (active[i] && (!a_fnd || weight[i] < a_w)) begin
                a_fnd = 1'b1;
                a_idx = IDX_W'(i);
                a_w   = weight[i];
                a_mem = member[i];
            end
        end
        for (int i = 0; i < NSYM; i++) begin
            if (active[i] && (IDX_W'(i) != a_idx) && (!b_fnd || weight[i] < b_w)) begin
                b_fnd = 1'b1;
                b_idx = IDX_W'(i);
                b_w   = weight[i];
                b_mem = member[i];
            end
        end
        lo_idx = (a_idx < b_idx) ? a_idx : b_idx;
        hi_idx = (a_idx < b_idx) ? b_idx : a_idx;
    end

    always_comb begin
        for (int s = 0; s < NSYM; s++) begin
            code_nxt[s] = code[s];
            len_nxt[s]  = len[s];
            if (a_mem[s]) begin
                code_nxt[s] = code[s] | (CODE_W'(1) << len[s]);
                len_nxt[s]  = len[s] + LEN_W'(1);
            end else if (b_mem[s]) begin
                len_nxt[s]  = len[s] + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= COUNT;
            sum        <= '0;
            CNT        <= '0;
            HC         <= '0;
            M          <= '0;
            CNT_valid  <= 1'b0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            active     <= '0;
            nact       <= '0;
            for (int i = 0; i < NSYM; i++) begin
                weight[i] <= '0;
                member[i] <= '0;
                code[i]   <= '0;
                len[i]    <= '0;
            end
        end else begin
            CNT_valid  <= 1'b0;
            code_valid <= 1'b0;
            case (state)
                COUNT: begin
                    for (int s = 0; s < NSYM; s++) begin
                        if (hit[s])
                            CNT[s*CNT_W +: CNT_W] <= CNT[s*CNT_W +: CNT_W] + CNT_W'(1);
                    end
                    if (|hit) begin
                        sum <= sum + CNT_W'(1);
                        if (sum == CNT_W'(TOTAL - 1)) begin
                            state     <= REPORT;
                            CNT_valid <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    for (int i = 0; i < NSYM; i++) begin
                        weight[i] <= CNT[i*CNT_W +: CNT_W];
                        member[i] <= NSYM'(1) << i;
                        active[i] <= |CNT[i*CNT_W +: CNT_W];
                        code[i]   <= '0;
                        len[i]    <= '0;
                    end
                    nact  <= nz_cnt;
                    state <= MERGE;
                end
                MERGE: begin
                    if (nact <= NACT_W'(1)) begin
                        // Single-symbol frame: a one-bit code of value 0.
                        for (int s = 0; s < NSYM; s++) begin
                            HC[s*CODE_W +: CODE_W] <= '0;
                            M[s*CODE_W +: CODE_W]  <= active[s] ? CODE_W'(1) : '0;
                        end
                        code_valid <= 1'b1;
                        state      <= OUT;
                    end else begin
                        for (int i = 0; i < NSYM; i++) begin
                            if (IDX_W'(i) == lo_idx) begin
                                weight[i] <= a_w + b_w;
                                member[i] <= a_mem | b_mem;
                            end
                            if (IDX_W'(i) == hi_idx)
                                active[i] <= 1'b0;
                        end
                        for (int s = 0; s < NSYM; s++) begin
                            code[s] <= code_nxt[s];
                            len[s]  <= len_nxt[s];
                        end
                        nact <= nact - NACT_W'(1);
                        if (nact == NACT_W'(2)) begin
                            for (int s = 0; s < NSYM; s++) begin
                                HC[s*CODE_W +: CODE_W] <= code_nxt[s];
                                M[s*CODE_W +: CODE_W]  <= len_mask(len_nxt[s]);
                            end
                            code_valid <= 1'b1;
                            state      <= OUT;
                        end
                    end
                end
                OUT: begin
`ifdef HUFF_RESTART_EN
                    state <= COUNT;
                    CNT   <= '0;
                    sum   <= '0;
                    busy  <= 1'b0;
`else
                    state <= DONE;
`endif
                end
                DONE: begin
                end
                default: state <= COUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_gen.sv
// tb_huffman_gen: randomized frames checked against a set-based Huffman reference model,
// plus directed frames for illegal symbols, ties, single-symbol frames, mid-merge reset and restart.
`timescale 1ns/1ps
module tb_huffman_gen;
    localparam int NSYM   = 6;
    localparam int CNT_W  = 8;
    localparam int TOTAL  = 100;
    localparam int CODE_W = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   gray_valid = 1'b0;
    logic [7:0]             gray_data = 8'd0;
    logic                   CNT_valid, code_valid, busy;
    logic [NSYM*CNT_W-1:0]  CNT;
    logic [NSYM*CODE_W-1:0] HC, M;

    int checks = 0;
    int errors = 0;
    int cnt_set  [NSYM];
    int exp_code [NSYM];
    int exp_len  [NSYM];
    int exp_k;
    logic [NSYM*CNT_W-1:0]  exp_cnt;
    logic [NSYM*CODE_W-1:0] exp_hc, exp_m, prev_hc;
    logic [7:0]             sd [$];
    logic                   sv [$];

    huffman_gen #(.NSYM(NSYM), .CNT_W(CNT_W), .TOTAL(TOTAL), .CODE_W(CODE_W)) dut (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
        .CNT_valid(CNT_valid), .CNT(CNT), .code_valid(code_valid),
        .HC(HC), .M(M), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int low_sym(input int m);
        for (int s = 0; s < NSYM; s++)
            if (m[s]) return s;
        return NSYM;
    endfunction

    // Node order: smaller weight first, then the node holding the lowest-numbered symbol.
    function automatic int pick(input int w [$], input int set [$], input int skip);
        int best = -1;
        int bkey = 0;
        int key;
        for (int i = 0; i < w.size(); i++) begin
            key = w[i] * 16 + low_sym(set[i]);
            if (i != skip && (best < 0 || key < bkey)) begin
                best = i;
                bkey = key;
            end
        end
        return best;
    endfunction

    task automatic build_model();
        int w [$];
        int set [$];
        int ia, ib, ma, mb;
        exp_cnt = '0;
        exp_hc  = '0;
        exp_m   = '0;
        for (int s = 0; s < NSYM; s++) begin
            exp_code[s] = 0;
            exp_len[s]  = 0;
            exp_cnt[s*CNT_W +: CNT_W] = CNT_W'(cnt_set[s]);
            if (cnt_set[s] > 0) begin
                w.push_back(cnt_set[s]);
                set.push_back(1 << s);
            end
        end
        exp_k = w.size();
        if (exp_k == 1) exp_len[low_sym(set[0])] = 1;
        while (w.size() > 1) begin
            ia = pick(w, set, -1);
            ib = pick(w, set, ia);
            ma = set[ia];
            mb = set[ib];
            for (int s = 0; s < NSYM; s++) begin
                if (ma[s]) begin
                    exp_code[s] = exp_code[s] | (1 << exp_len[s]);
                    exp_len[s]++;
                end else if (mb[s]) begin
                    exp_len[s]++;
                end
            end
            w.push_back(w[ia] + w[ib]);
            set.push_back(ma | mb);
            if (ia > ib) begin
                w.delete(ia); set.delete(ia); w.delete(ib); set.delete(ib);
            end else begin
                w.delete(ib); set.delete(ib); w.delete(ia); set.delete(ia);
            end
        end
        for (int s = 0; s < NSYM; s++) begin
            exp_hc[s*CODE_W +: CODE_W] = CODE_W'(exp_code[s]);
            exp_m[s*CODE_W +: CODE_W]  = CODE_W'((1 << exp_len[s]) - 1);
        end
    endtask

    task automatic rand_counts();
        int k;
        int chosen = 0;
        int rem;
        int s;
        int add;
        k = $urandom_range(NSYM, 1);
        for (int i = 0; i < NSYM; i++) cnt_set[i] = 0;
        while (chosen < k) begin
            s = $urandom_range(NSYM - 1, 0);
            if (cnt_set[s] == 0) begin
                cnt_set[s] = 1;
                chosen++;
            end
        end
        rem = TOTAL - k;
        while (rem > 0) begin
            s = $urandom_range(NSYM - 1, 0);
            if (cnt_set[s] > 0) begin
                add = $urandom_range(rem, 1);
                cnt_set[s] += add;
                rem -= add;
            end
        end
    endtask

    task automatic set_counts(input int c0, c1, c2, c3, c4, c5);
        cnt_set[0] = c0; cnt_set[1] = c1; cnt_set[2] = c2;
        cnt_set[3] = c3; cnt_set[4] = c4; cnt_set[5] = c5;
    endtask

    // Shuffled legal samples with optional idle cycles and illegal symbols; the stream ends on a legal sample.
    task automatic make_stim(input int illegal_pct, input int idle_pct);
        logic [7:0] legal [$];
        logic [7:0] t;
        int j;
        sd.delete();
        sv.delete();
        for (int s = 0; s < NSYM; s++)
            for (int n = 0; n < cnt_set[s]; n++) legal.push_back(8'(s + 1));
        for (int i = legal.size() - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = legal[i];
            legal[i] = legal[j];
            legal[j] = t;
        end
        for (int i = 0; i < legal.size(); i++) begin
            if ($urandom_range(99, 0) < idle_pct) begin
                sv.push_back(1'b0);
                sd.push_back(8'($urandom));
            end
            if ($urandom_range(99, 0) < illegal_pct) begin
                sv.push_back(1'b1);
                case ($urandom_range(3, 0))
                    0: sd.push_back(8'd0);
                    1: sd.push_back(8'd7);
                    2: sd.push_back(8'd255);
                    default: sd.push_back(8'($urandom_range(255, 7)));
                endcase
            end
            sv.push_back(1'b1);
            sd.push_back(legal[i]);
        end
        build_model();
    endtask

    task automatic do_reset();
        gray_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset:flags", 64'({CNT_valid, code_valid, busy}), 64'(0));
        check("reset:cnt", 64'(CNT), 64'(0));
        check("reset:hc_m", 64'(HC | M), 64'(0));
        reset = 1'b0;
    endtask

    task automatic feed_frame(input string tag);
        logic early = 1'b0;
        for (int i = 0; i < sv.size(); i++) begin
            gray_valid = sv[i];
            gray_data  = sd[i];
            @(negedge clk);
            if (i < sv.size() - 1 && CNT_valid) early = 1'b1;
        end
        gray_valid = 1'b0;
        gray_data  = 8'd0;
        check({tag, ":early_cnt_valid"}, 64'(early), 64'(0));
        check({tag, ":cnt_valid"}, 64'(CNT_valid), 64'(1));
        check({tag, ":cnt"}, 64'(CNT), 64'(exp_cnt));
        check({tag, ":busy"}, 64'(busy), 64'(1));
    endtask

    task automatic finish_frame(input string tag);
        int lat = -1;
        int want;
        want = 1 + ((exp_k - 1 > 1) ? exp_k - 1 : 1);
        for (int n = 1; n <= 3 * NSYM; n++) begin
            @(negedge clk);
            if (code_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, ":latency"}, 64'(lat), 64'(want));
        check({tag, ":hc"}, 64'(HC), 64'(exp_hc));
        check({tag, ":m"}, 64'(M), 64'(exp_m));
        check({tag, ":cnt_hold"}, 64'(CNT), 64'(exp_cnt));
        @(negedge clk);
        check({tag, ":code_pulse"}, 64'(code_valid), 64'(0));
    endtask

    initial begin
        logic stray;

        do_reset();

        // Reference distribution with known codes.
        set_counts(40, 20, 15, 10, 10, 5);
        make_stim(0, 20);
        feed_frame("ref");
        finish_frame("ref");
        check("ref:hc_const", 64'(HC), 64'h030302020001);
        check("ref:m_const", 64'(M), 64'h0F070F070701);

`ifdef HUFF_RESTART_EN
        check("restart:busy", 64'(busy), 64'(0));
        check("restart:cnt_clear", 64'(CNT), 64'(0));
        prev_hc = HC;
        rand_counts();
        make_stim(10, 10);
        check("restart:hc_kept", 64'(HC), 64'(prev_hc));
        feed_frame("frame2");
        finish_frame("frame2");
`else
        stray = 1'b0;
        for (int i = 0; i < TOTAL + 10; i++) begin
            gray_valid = 1'b1;
            gray_data  = 8'($urandom_range(NSYM, 1));
            @(negedge clk);
            if (CNT_valid || code_valid || !busy) stray = 1'b1;
        end
        gray_valid = 1'b0;
        check("done:ignored", 64'(stray), 64'(0));
        check("done:cnt_hold", 64'(CNT), 64'(exp_cnt));
        check("done:hc_hold", 64'(HC), 64'h030302020001);
`endif

        // Single-symbol frame.
        do_reset();
        set_counts(0, 0, 100, 0, 0, 0);
        make_stim(0, 0);
        feed_frame("single");
        finish_frame("single");
        check("single:m_const", 64'(M), 64'h000000010000);

        // Illegal symbol values mixed into the stream.
        do_reset();
        rand_counts();
        make_stim(40, 10);
        feed_frame("illegal");
        finish_frame("illegal");

        // Two-way tie.
        do_reset();
        set_counts(50, 50, 0, 0, 0, 0);
        make_stim(0, 0);
        feed_frame("tie");
        finish_frame("tie");
        check("tie:hc_const", 64'(HC), 64'h000000000001);
        check("tie:m_const", 64'(M), 64'h000000000101);

        // Reset during the third merge cycle.
        do_reset();
        set_counts(40, 20, 15, 10, 10, 5);
        make_stim(0, 0);
        feed_frame("midrst");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("midrst:pre_busy", 64'({busy, code_valid}), 64'(2));
        reset = 1'b1;
        #1;
        check("midrst:flags", 64'({CNT_valid, code_valid, busy}), 64'(0));
        check("midrst:cnt", 64'(CNT), 64'(0));
        check("midrst:hc_m", 64'(HC | M), 64'(0));
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 1) reset = 1'b0;
            if (code_valid || CNT_valid) stray = 1'b1;
        end
        check("midrst:no_code", 64'(stray), 64'(0));
        rand_counts();
        make_stim(10, 10);
        feed_frame("postrst");
        finish_frame("postrst");

        // Random frames.
        for (int f = 0; f < 8; f++) begin
            do_reset();
            rand_counts();
            make_stim(15, 15);
            feed_frame("rand");
            finish_frame("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
